// File: rtl/unimem_ws.sv
// Unified instruction/data memory with programmable wait states, byte-enable writes
// and out-of-range error reporting behind a single req/ready handshake.
module unimem_ws #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned DEPTH     = 64,
  parameter int unsigned WAIT      = 2,
  parameter string       INIT_FILE = ""
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req,
  input  logic               we,
  input  logic [WIDTH/8-1:0] be,
  input  logic [31:0]        adr,
  input  logic [WIDTH-1:0]   wd,
  output logic [WIDTH-1:0]   rd,
  output logic               ready,
  output logic               busy,
  output logic               err
);

  localparam int unsigned NB = WIDTH / 8;
  localparam int unsigned AB = (NB > 1) ? $clog2(NB) : 0;
  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  logic [WIDTH-1:0] r_mem [DEPTH];

  state_e           r_state, w_state_d;
  logic [3:0]       r_cnt, w_cnt_d;
  logic             r_we, r_oor;
  logic [NB-1:0]    r_be;
  logic [WIDTH-1:0] r_wd, r_rd;
  logic [IW-1:0]    r_idx;
  logic             r_ready, r_err;

  logic [31:0]      w_word;
  logic             w_oor, w_accept, w_fire;
  logic             w_acc_we, w_acc_oor;
  logic [NB-1:0]    w_acc_be;
  logic [WIDTH-1:0] w_acc_wd;
  logic [IW-1:0]    w_acc_idx;

  assign w_word   = adr >> AB;
  assign w_oor    = (w_word >= DEPTH);
  assign w_accept = req && (r_state != StWait);

  // With WAIT=0 the access completes on its accept edge, so it uses the live inputs.
  always_comb begin
    w_acc_we  = we;
    w_acc_be  = be;
    w_acc_wd  = wd;
    w_acc_idx = w_word[IW-1:0];
    w_acc_oor = w_oor;
    if (r_state == StWait) begin
      w_acc_we  = r_we;
      w_acc_be  = r_be;
      w_acc_wd  = r_wd;
      w_acc_idx = r_idx;
      w_acc_oor = r_oor;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_fire    = 1'b0;
    unique case (r_state)
      StIdle, StDone: begin
        if (req) begin
          w_cnt_d   = 4'(WAIT);
          w_state_d = (WAIT == 0) ? StDone : StWait;
          w_fire    = (WAIT == 0);
        end else begin
          w_state_d = StIdle;
        end
      end
      StWait: begin
        if (r_cnt == 4'd0) begin
          w_state_d = StDone;
          w_fire    = 1'b1;
        end else begin
          w_cnt_d = r_cnt - 4'd1;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StIdle;
      r_cnt   <= 4'd0;
      r_ready <= 1'b0;
      r_err   <= 1'b0;
      r_rd    <= '0;
      r_we    <= 1'b0;
      r_oor   <= 1'b0;
      r_be    <= '0;
      r_wd    <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_ready <= w_fire;
      r_err   <= w_fire && w_acc_oor;
      if (w_fire && w_acc_oor) begin
        r_rd <= '0;
      end else if (w_fire && !w_acc_we) begin
        r_rd <= r_mem[w_acc_idx];
      end
      if (w_accept) begin
        r_we  <= we;
        r_oor <= w_oor;
        r_be  <= be;
        r_wd  <= wd;
        r_idx <= w_word[IW-1:0];
      end
    end
  end

  // Array has no reset; a reset edge suppresses the pending write.
  always_ff @(posedge clk) begin
    if (!reset && w_fire && w_acc_we && !w_acc_oor) begin
      for (int i = 0; i < int'(NB); i++) begin
        if (w_acc_be[i]) r_mem[w_acc_idx][i*8 +: 8] <= w_acc_wd[i*8 +: 8];
      end
    end
  end

  assign rd    = r_rd;
  assign ready = r_ready;
  assign err   = r_err;
  assign busy  = (r_state == StWait);

endmodule

// File: tb/tb_unimem_ws.sv
// Scoreboard bench for unimem_ws: three instances with WAIT = 2, 0 and 3.
module tb_unimem_ws;

  typedef struct {
    int          inst;
    logic [31:0] rd;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  req, we, ready, busy, err;
  logic [3:0]  be  [3];
  logic [31:0] adr [3];
  logic [31:0] wd  [3];
  logic [31:0] rd  [3];

  exp_t        sb_q[$];
  logic [31:0] last_rd [3];
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  for (genvar k = 0; k < 3; k++) begin : g_dut
    unimem_ws #(
      .WIDTH    (32),
      .DEPTH    (64),
      .WAIT     ((k == 0) ? 2 : ((k == 1) ? 0 : 3)),
      .INIT_FILE("")
    ) u_dut (
      .clk  (clk),
      .reset(reset),
      .req  (req[k]),
      .we   (we[k]),
      .be   (be[k]),
      .adr  (adr[k]),
      .wd   (wd[k]),
      .rd   (rd[k]),
      .ready(ready[k]),
      .busy (busy[k]),
      .err  (err[k])
    );
  end

  function automatic int wait_of(input int k);
    return (k == 0) ? 2 : ((k == 1) ? 0 : 3);
  endfunction

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic expect_done(input int k, input logic [31:0] exp_rd, input logic exp_err);
    exp_t e;
    e.inst = k;
    e.rd   = exp_rd;
    e.err  = exp_err;
    sb_q.push_back(e);
    last_rd[k] = exp_rd;
  endtask

  // Single access; optional glitch pulses req while the access is still busy.
  task automatic access(input int k, input logic w, input logic [3:0] b, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] exp_rd, input logic exp_err,
                        input bit glitch);
    int n = 0;
    expect_done(k, exp_rd, exp_err);
    @(negedge clk);
    req[k] = 1'b1; we[k] = w; be[k] = b; adr[k] = a; wd[k] = d;
    @(posedge clk);
    #1 req[k] = 1'b0;
    check_val("busy_after_accept", 32'(busy[k]), 32'(wait_of(k) != 0));
    @(negedge clk);
    while (ready[k] !== 1'b1 && n < 40) begin
      if (glitch && n == 1) req[k] = 1'b1;
      if (glitch && n == 2) req[k] = 1'b0;
      @(negedge clk);
      n++;
    end
    check_val("latency", 32'(n), 32'((wait_of(k) == 0) ? 0 : wait_of(k) + 1));
    check_val("busy_in_done", 32'(busy[k]), 32'd0);
    @(negedge clk);
    check_val("ready_one_cycle", 32'(ready[k]), 32'd0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      if (ready[k] === 1'b1) begin
        if (sb_q.size() == 0) begin
          check_val("spurious_ready", 32'(k), 32'hFFFF_FFFF);
        end else begin
          e = sb_q.pop_front();
          check_val("sb_inst", 32'(k), 32'(e.inst));
          check_val("sb_rd", rd[k], e.rd);
          check_val("sb_err", 32'(err[k]), 32'(e.err));
        end
      end else if (err[k] !== 1'b0) begin
        check_val("err_without_ready", 32'(err[k]), 32'd0);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic        b2b_we   [5];
    logic [31:0] b2b_adr  [5];
    logic [31:0] b2b_wd   [5];
    logic [31:0] b2b_exp  [5];

    reset = 1'b1;
    req   = '0;
    we    = '0;
    for (int k = 0; k < 3; k++) begin
      be[k] = '0; adr[k] = '0; wd[k] = '0; last_rd[k] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    repeat (5) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        check_val("idle_ready", 32'(ready[k]), 32'd0);
        check_val("idle_busy", 32'(busy[k]), 32'd0);
        check_val("idle_err", 32'(err[k]), 32'd0);
        check_val("idle_rd", rd[k], 32'd0);
      end
    end

    // WAIT=2 instance: basic, byte enables, aliasing low bits, range boundary.
    access(0, 1'b1, 4'hF, 32'h00, 32'hCAFE_F00D, last_rd[0], 1'b0, 1'b0);
    access(0, 1'b1, 4'hF, 32'h10, 32'hDEAD_BEEF, last_rd[0], 1'b0, 1'b0);
    access(0, 1'b0, 4'h0, 32'h10, 32'h0,         32'hDEAD_BEEF, 1'b0, 1'b0);
    access(0, 1'b0, 4'h0, 32'h12, 32'h0,         32'hDEAD_BEEF, 1'b0, 1'b0);
    access(0, 1'b1, 4'b0101, 32'h10, 32'h1122_3344, last_rd[0], 1'b0, 1'b0);
    access(0, 1'b0, 4'h0, 32'h10, 32'h0,         32'hDE22_BE44, 1'b0, 1'b0);
    access(0, 1'b1, 4'hF, 32'h100, 32'h5555_5555, 32'h0, 1'b1, 1'b0);
    access(0, 1'b0, 4'h0, 32'h100, 32'h0,         32'h0, 1'b1, 1'b0);
    access(0, 1'b0, 4'h0, 32'h00, 32'h0,          32'hCAFE_F00D, 1'b0, 1'b0);
    access(0, 1'b1, 4'hF, 32'hFC, 32'hA5A5_A5A5,  last_rd[0], 1'b0, 1'b0);
    access(0, 1'b0, 4'h0, 32'hFC, 32'h0,          32'hA5A5_A5A5, 1'b0, 1'b0);

    // WAIT=0 instance: preload, then back-to-back write + reads (RAW in DONE cycle).
    access(1, 1'b1, 4'hF, 32'h44, 32'h0A0B_0C0D, last_rd[1], 1'b0, 1'b0);
    access(1, 1'b1, 4'hF, 32'h48, 32'h1020_3040, last_rd[1], 1'b0, 1'b0);
    b2b_we  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    b2b_adr = '{32'h40, 32'h40, 32'h44, 32'h48, 32'h44};
    b2b_wd  = '{32'h1111_2222, 32'h0, 32'h0, 32'h0, 32'h0};
    b2b_exp = '{last_rd[1], 32'h1111_2222, 32'h0A0B_0C0D, 32'h1020_3040, 32'h0A0B_0C0D};
    for (int i = 0; i < 5; i++) expect_done(1, b2b_exp[i], 1'b0);
    @(negedge clk);
    req[1] = 1'b1; we[1] = b2b_we[0]; be[1] = 4'hF; adr[1] = b2b_adr[0]; wd[1] = b2b_wd[0];
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      if (i < 4) begin
        we[1] = b2b_we[i+1]; adr[1] = b2b_adr[i+1]; wd[1] = b2b_wd[i+1];
      end else begin
        req[1] = 1'b0;
      end
      @(negedge clk);
      check_val("b2b_ready", 32'(ready[1]), 32'd1);
    end
    @(negedge clk);
    check_val("b2b_ready_end", 32'(ready[1]), 32'd0);

    // WAIT=3 instance: req during busy ignored.
    access(2, 1'b1, 4'hF, 32'h20, 32'h1234_5678, last_rd[2], 1'b0, 1'b0);
    access(2, 1'b0, 4'h0, 32'h20, 32'h0,         32'h1234_5678, 1'b0, 1'b1);
    repeat (8) @(negedge clk);

    // Reset while cnt=1 during a write: access abandoned, array untouched.
    @(negedge clk);
    req[2] = 1'b1; we[2] = 1'b1; be[2] = 4'hF; adr[2] = 32'h20; wd[2] = 32'hFFFF_FFFF;
    @(posedge clk);
    #1 req[2] = 1'b0;
    repeat (3) @(negedge clk);
    check_val("busy_before_reset", 32'(busy[2]), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check_val("rst_ready", 32'(ready[2]), 32'd0);
    check_val("rst_busy", 32'(busy[2]), 32'd0);
    check_val("rst_err", 32'(err[2]), 32'd0);
    check_val("rst_rd", rd[2], 32'd0);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) last_rd[k] = '0;
    repeat (6) @(negedge clk);
    access(2, 1'b0, 4'h0, 32'h20, 32'h0, 32'h1234_5678, 1'b0, 1'b0);

    repeat (5) @(negedge clk);
    check_val("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
